// File: rtl/util_demux4_stream_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package util_pkg;

   typedef logic [1:0] lane_sel_t;

   localparam int unsigned NLANES = 4;

   localparam lane_sel_t LANE0 = 2'd0;
   localparam lane_sel_t LANE1 = 2'd1;
   localparam lane_sel_t LANE2 = 2'd2;
   localparam lane_sel_t LANE3 = 2'd3;

endpackage

// File: rtl/util_demux4_stream_lane_reg.sv
// One-entry output holding register with a valid/ready handshake.
module util_lane_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] wr_data,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data
);

   // Valid flag: a write wins over a same-cycle drain so a lane can reload back-to-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (wr) begin
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

   // Data register: replaced only on a write; a drain leaves the old word in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (wr) begin
         data <= wr_data;
      end
   end

endmodule

// File: rtl/util_demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with optional all-lane broadcast.
module util_demux4_stream
   import util_pkg::*;
#(
   parameter int unsigned A = 7,
   parameter int unsigned B = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  lane_sel_t         in_ctrl,
   input  logic              in_bcast,
   input  logic [A:B]        in_data,
   output logic [NLANES-1:0] out_valid,
   input  logic [NLANES-1:0] out_ready,
   output logic [A:B]        out_data0,
   output logic [A:B]        out_data1,
   output logic [A:B]        out_data2,
   output logic [A:B]        out_data3
);

   localparam int unsigned W = A - B + 1;

   logic [NLANES-1:0] free;
   logic [NLANES-1:0] wr;
   logic              accept;
   logic [W-1:0]      lane_data [NLANES];

   assign free   = ~out_valid | out_ready;
   assign accept = in_valid && in_ready;

   // Input ready: target lane free, or every lane free for a broadcast; never during reset.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         if (in_bcast) begin
            in_ready = &free;
         end else begin
            in_ready = free[in_ctrl];
         end
      end
   end

   // Select decode and per-lane holding registers.
   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      assign wr[k] = accept && (in_bcast || (in_ctrl == lane_sel_t'(k)));

      util_lane_reg #(
         .W (W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr[k]),
         .wr_data (in_data),
         .valid   (out_valid[k]),
         .ready   (out_ready[k]),
         .data    (lane_data[k])
      );
   end

   assign out_data0 = lane_data[LANE0];
   assign out_data1 = lane_data[LANE1];
   assign out_data2 = lane_data[LANE2];
   assign out_data3 = lane_data[LANE3];

endmodule

// File: tb/tb_util_demux4_stream.sv
// Directed plus randomized bench for util_demux4_stream against a lane-array model.
module tb_util_demux4_stream;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_ctrl;
   logic       in_bcast;
   logic [7:0] in_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data0, out_data1, out_data2, out_data3;

   int checks = 0;
   int errors = 0;

   // Model: what each lane currently holds
   bit         m_full [4];
   logic [7:0] m_word [4];

   util_demux4_stream #(.A(7), .B(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_bcast  (in_bcast),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = m_full[k];
      return v;
   endfunction

   // Expected readiness: a word goes in only if every lane it targets can take it
   function automatic logic model_ready(input logic r, input logic [1:0] ctrl,
                                        input logic bc, input logic [3:0] ordy);
      int blocked = 0;
      if (r) return 1'b0;
      for (int k = 0; k < 4; k++)
         if ((bc || ctrl == 2'(k)) && m_full[k] && !ordy[k]) blocked++;
      return (blocked == 0);
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(model_valid()));
      chk({tag, ".d0"}, 32'(out_data0), 32'(m_word[0]));
      chk({tag, ".d1"}, 32'(out_data1), 32'(m_word[1]));
      chk({tag, ".d2"}, 32'(out_data2), 32'(m_word[2]));
      chk({tag, ".d3"}, 32'(out_data3), 32'(m_word[3]));
   endtask

   // One clock: apply inputs, check in_ready, advance model and DUT, check lanes
   task automatic step(input string tag, input logic r, input logic v, input logic [1:0] ctrl,
                       input logic bc, input logic [7:0] d, input logic [3:0] ordy,
                       input bit full_check);
      logic exp_rdy;
      @(negedge clk);
      rst = r; in_valid = v; in_ctrl = ctrl; in_bcast = bc; in_data = d; out_ready = ordy;
      #1;
      exp_rdy = model_ready(r, ctrl, bc, ordy);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < 4; k++) begin m_full[k] = 0; m_word[k] = 8'h00; end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (v && exp_rdy && (bc || ctrl == 2'(k))) begin
               m_full[k] = 1; m_word[k] = d;
            end else if (m_full[k] && ordy[k]) begin
               m_full[k] = 0;
            end
         end
      end
      if (full_check) check_outputs(tag);
      else chk({tag, ".valid"}, 32'(out_valid), 32'(model_valid()));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ctrl = 2'd0; in_bcast = 1'b0;
      in_data = 8'h00; out_ready = 4'h0;
      for (int k = 0; k < 4; k++) begin m_full[k] = 0; m_word[k] = 8'h00; end

      // Reset with a word presented: must not be taken
      step("rst0", 1, 1, 2'd1, 0, 8'hEE, 4'h0, 1);
      step("rst1", 1, 1, 2'd1, 0, 8'hEE, 4'h0, 1);
      step("idle", 0, 0, 2'd0, 0, 8'h00, 4'h0, 1);
      chk("idle.literal_valid", 32'(out_valid), 32'h0);

      // Routing, back to back
      step("rt0", 0, 1, 2'd0, 0, 8'hA0, 4'hF, 1);
      chk("rt0.lit", 32'(out_data0), 32'hA0);
      step("rt1", 0, 1, 2'd1, 0, 8'hA1, 4'hF, 1);
      step("rt2", 0, 1, 2'd2, 0, 8'hA2, 4'hF, 1);
      step("rt3", 0, 1, 2'd3, 0, 8'hA3, 4'hF, 1);
      chk("rt3.lit_valid", 32'(out_valid), 32'h8);
      step("rt_end", 0, 0, 2'd0, 0, 8'h00, 4'hF, 1);

      // Backpressure on lane 2, then same-edge reload
      step("bp55", 0, 1, 2'd2, 0, 8'h55, 4'b1011, 1);
      step("bp66", 0, 1, 2'd2, 0, 8'h66, 4'b1011, 1);
      chk("bp66.lit_d2", 32'(out_data2), 32'h55);
      step("rel66", 0, 1, 2'd2, 0, 8'h66, 4'b1111, 1);
      chk("rel66.lit_d2", 32'(out_data2), 32'h66);
      chk("rel66.lit_v2", 32'(out_valid[2]), 32'h1);
      step("bp_end", 0, 0, 2'd0, 0, 8'h00, 4'hF, 1);

      // Broadcast blocked by a stalled lane 1, then released
      step("fill1", 0, 1, 2'd1, 0, 8'h9A, 4'b1101, 1);
      step("bcblk", 0, 1, 2'd0, 1, 8'hC3, 4'b1101, 1);
      step("bcrel", 0, 1, 2'd0, 1, 8'hC3, 4'b1111, 1);
      chk("bcrel.lit_valid", 32'(out_valid), 32'hF);
      step("bc_end", 0, 0, 2'd0, 0, 8'h00, 4'hF, 1);

      // Lane 0 stalled while lanes 1 and 3 flow
      step("ind0", 0, 1, 2'd0, 0, 8'h11, 4'b1110, 1);
      step("ind1", 0, 1, 2'd1, 0, 8'h22, 4'b1110, 1);
      step("ind3", 0, 1, 2'd3, 0, 8'h33, 4'b1110, 1);
      step("ind_d", 0, 0, 2'd0, 0, 8'h00, 4'b1110, 1);
      chk("ind.lit_d0", 32'(out_data0), 32'h11);
      chk("ind.lit_valid", 32'(out_valid), 32'h1);

      // Reset mid-operation with lanes 0 and 3 stalled
      step("mr3", 0, 1, 2'd3, 0, 8'h77, 4'b0110, 1);
      step("mrst", 1, 0, 2'd0, 0, 8'h00, 4'b0110, 1);
      chk("mrst.lit_valid", 32'(out_valid), 32'h0);
      step("mr_after0", 0, 0, 2'd0, 0, 8'h00, 4'hF, 1);
      step("mr_after1", 0, 0, 2'd0, 0, 8'h00, 4'h0, 1);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 59) == 0), 1'($urandom), 2'($urandom),
              ($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
